// File: rtl/rsa4k_pkg.sv
// Shared constants and FSM state encoding for the rsa4k modular exponentiator.
package rsa4k_pkg;

    localparam int RSA4K_WIDTH = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQUARE,
        MULT,
        NEXT,
        DONE
    } state_t;

endpackage

// File: rtl/rsa4k_modmul.sv
// Bit-serial interleaved (Blakley) modular multiplier: p = a*b mod n, MSB of a first.
// done pulses for one cycle exactly WIDTH+1 cycles after the cycle start is seen.
module rsa4k_modmul
    import rsa4k_pkg::*;
#(
    parameter int WIDTH = RSA4K_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] p,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH+1:0] acc;
    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] red;
    logic [CW-1:0]    cnt;
    logic             busy;

    // With acc < n and b < n the sum stays below 3n, so two subtractions always suffice.
    always_comb begin
        sum = (acc << 1) + (a_q[WIDTH-1] ? {2'b00, b_q} : '0);
        if (sum >= {1'b0, n_q, 1'b0}) begin
            red = sum - {1'b0, n_q, 1'b0};
        end else if (sum >= {2'b00, n_q}) begin
            red = sum - {2'b00, n_q};
        end else begin
            red = sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q  <= '0;
            b_q  <= '0;
            n_q  <= '0;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                a_q  <= a;
                b_q  <= b;
                n_q  <= n;
                acc  <= '0;
                cnt  <= CW'(WIDTH);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= red;
                a_q <= a_q << 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign p = acc[WIDTH-1:0];

endmodule

// File: rtl/rsa4k.sv
// Left-to-right square-and-multiply modular exponentiator: cypher = message^exponent mod modulus.
// Define RSA4K_SKIP_LEADING_ZEROS_EN to skip leading zero exponent bits in LOAD (latency only).
//
// state  | meaning
// IDLE   | waiting for go; operands registered when go is seen
// LOAD   | R = 1, bit index at top (optionally walks past leading zeros)
// SQUARE | R = R*R mod N
// MULT   | R = R*M mod N when the current exponent bit is set
// NEXT   | step to the next lower bit or finish
// DONE   | result valid, held while go stays high
module rsa4k
    import rsa4k_pkg::*;
#(
    parameter int WIDTH = RSA4K_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] message,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] cypher,
    output logic             done
);

    localparam int IW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] r;
    logic [IW-1:0]    i;
    logic             mm_start;
    logic [WIDTH-1:0] mm_b;
    logic [WIDTH-1:0] mm_p;
    logic             mm_done;

    rsa4k_modmul #(.WIDTH(WIDTH)) u_modmul (
        .clk   (clk),
        .reset (reset),
        .start (mm_start),
        .a     (r),
        .b     (mm_b),
        .n     (n_q),
        .p     (mm_p),
        .done  (mm_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = LOAD;
            LOAD: begin
`ifdef RSA4K_SKIP_LEADING_ZEROS_EN
                if (e_q[i])         state_next = SQUARE;
                else if (i == '0)   state_next = DONE;
`else
                state_next = SQUARE;
`endif
            end
            SQUARE:  if (mm_done) state_next = e_q[i] ? MULT : NEXT;
            MULT:    if (mm_done) state_next = NEXT;
            NEXT:    state_next = (i == '0) ? DONE : SQUARE;
            DONE:    if (!go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        done = (state == DONE);
        mm_b = (state == MULT) ? m_q : r;
    end

    // The multiplier start is delayed one cycle so it sees R already updated by the previous product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q      <= '0;
            e_q      <= '0;
            n_q      <= '0;
            r        <= '0;
            i        <= '0;
            cypher   <= '0;
            mm_start <= 1'b0;
        end else begin
            mm_start <= (state_next != state) && (state_next == SQUARE || state_next == MULT);
            case (state)
                IDLE: begin
                    if (go) begin
                        m_q <= message;
                        e_q <= exponent;
                        n_q <= modulus;
                        i   <= IW'(WIDTH - 1);
                    end
                end
                LOAD: begin
                    r <= WIDTH'(1);
`ifdef RSA4K_SKIP_LEADING_ZEROS_EN
                    if (!e_q[i] && i != '0) i <= i - IW'(1);
`else
                    i <= IW'(WIDTH - 1);
`endif
                    if (state_next == DONE) cypher <= WIDTH'(1);
                end
                SQUARE, MULT: begin
                    if (mm_done) r <= mm_p;
                end
                NEXT: begin
                    if (i == '0) cypher <= r;
                    else         i <= i - IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa4k.sv
// Scoreboard bench for rsa4k at a reduced width; the driver queues expected results, the monitor checks on done.
module tb_rsa4k;

    localparam int W     = 16;
    localparam int BOUND = W * (2 * (W + 1) + 3) + 4;

    typedef struct {
        logic [W-1:0] value;
        string        name;
        bit           dont_care;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         go;
    logic [W-1:0] message;
    logic [W-1:0] exponent;
    logic [W-1:0] modulus;
    logic [W-1:0] cypher;
    logic         done;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb_q[$];
    logic done_d = 1'b0;

    rsa4k #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .message  (message),
        .exponent (exponent),
        .modulus  (modulus),
        .cypher   (cypher),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: every rising edge of done consumes one scoreboard entry.
    always @(negedge clk) begin
        exp_t x;
        if (done === 1'b1 && done_d !== 1'b1) begin
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: done rose with nothing pending, cypher %0d", cypher);
            end else begin
                x = sb_q.pop_front();
                if (!x.dont_care) check(x.name, cypher, x.value);
            end
        end
        done_d = done;
    end

    task automatic job(input string name, input logic [W-1:0] m, input logic [W-1:0] e,
                       input logic [W-1:0] n, input logic [W-1:0] want,
                       input bit hold, input bit dc);
        int   cycles;
        exp_t x;
        x.value     = want;
        x.name      = name;
        x.dont_care = dc;
        sb_q.push_back(x);
        message  = m;
        exponent = e;
        modulus  = n;
        go       = 1'b1;
        @(posedge clk); #1;
        message  = W'($urandom);
        exponent = W'($urandom);
        modulus  = W'($urandom);
        if (!hold) go = 1'b0;
        cycles = 0;
        while (done !== 1'b1 && cycles <= BOUND) begin
            @(posedge clk); #1;
            cycles++;
        end
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_latency: done not seen within %0d cycles", name, BOUND);
            sb_q.delete();
            go    = 1'b0;
            reset = 1'b0;
            @(posedge clk); #1;
            reset = 1'b1;
            @(posedge clk); #1;
            return;
        end
        if (hold) begin
            repeat (3) @(posedge clk);
            #1;
            check({name, "_hold_done"}, W'(done), W'(1));
            if (!dc) check({name, "_hold_cypher"}, cypher, want);
            go = 1'b0;
        end
        @(posedge clk); #1;
        check({name, "_done_drop"}, W'(done), W'(0));
        if (!dc) check({name, "_cypher_keep"}, cypher, want);
    endtask

    initial begin
        int bad;
        reset    = 1'b0;
        go       = 1'b0;
        message  = '0;
        exponent = '0;
        modulus  = '0;
        #3;
        check("reset_done", W'(done), W'(0));
        check("reset_cypher", cypher, W'(0));
        @(negedge clk);
        reset = 1'b1;

        bad = 0;
        repeat (10000) begin
            @(negedge clk);
            if (done !== 1'b0 || cypher !== '0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle_soak: %0d cycles with done/cypher nonzero, required 0", bad);
        end
        @(posedge clk); #1;

        job("m8_e13_n77", 16'd8, 16'd13, 16'd77, 16'd50, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("pulse_reset_cypher", cypher, W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        job("m50_e37_n77",      16'd50,    16'd37,     16'd77,    16'd8,     1'b1, 1'b0);
        job("m8_e0_n77",        16'd8,     16'd0,      16'd77,    16'd1,     1'b0, 1'b0);
        job("m8_e1_n77",        16'd8,     16'd1,      16'd77,    16'd8,     1'b0, 1'b0);
        job("m2_ew_nmax",       16'd2,     16'd16,     16'd65535, 16'd1,     1'b1, 1'b0);
        job("m3_e5_n7",         16'd3,     16'd5,      16'd7,     16'd5,     1'b0, 1'b0);
        job("m2_e10_n1000",     16'd2,     16'd10,     16'd1000,  16'd24,    1'b0, 1'b0);
        job("m0_e5_n77",        16'd0,     16'd5,      16'd77,    16'd0,     1'b0, 1'b0);
        job("m76_e2_n77",       16'd76,    16'd2,      16'd77,    16'd1,     1'b0, 1'b0);
        job("m76_e3_n77",       16'd76,    16'd3,      16'd77,    16'd76,    1'b0, 1'b0);
        job("neg1_eones_p",     16'd65520, 16'hFFFF,   16'd65521, 16'd65520, 1'b1, 1'b0);
        job("m2_eones_nmax",    16'd2,     16'hFFFF,   16'd65535, 16'd32768, 1'b0, 1'b0);
        job("bad_m_ge_n",       16'd100,   16'hFFFF,   16'd77,    16'd0,     1'b0, 1'b1);
        job("n2_m1_e3",         16'd1,     16'd3,      16'd2,     16'd1,     1'b0, 1'b0);
        job("n2_m0_e0",         16'd0,     16'd0,      16'd2,     16'd1,     1'b0, 1'b0);

        // Reset while the first SQUARE of a job is running.
        message  = 16'd8;
        exponent = 16'd13;
        modulus  = 16'd77;
        go       = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midjob_reset_done", W'(done), W'(0));
        check("midjob_reset_cypher", cypher, W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        job("after_midjob_reset", 16'd8, 16'd13, 16'd77, 16'd50, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d results still pending, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rsa4k.md
RSA4K -- requirements
Module: rsa4k

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4096, giving the operand/result bit width; all vectors below are WIDTH bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port go, input, 1 bit: level start request; operands are sampled when a job starts.
REQ-005 The block SHALL have port message, input, WIDTH bits: base M; precondition M < modulus.
REQ-006 The block SHALL have port exponent, input, WIDTH bits: exponent E, unsigned.
REQ-007 The block SHALL have port modulus, input, WIDTH bits: modulus N; precondition N >= 2.
REQ-008 The block SHALL have port cypher, output, WIDTH bits: result M^E mod N.
REQ-009 The block SHALL have port done, output, 1 bit: result valid.

Function
REQ-010 FSM states SHALL be IDLE, LOAD, SQUARE, MULT, NEXT, DONE.
REQ-011 In IDLE with go=1, the block SHALL register M, E and N and go to LOAD; later input changes have no effect on the running job.
REQ-012 In LOAD, the block SHALL set accumulator R=1 and bit index i=WIDTH-1.
REQ-013 Algorithm is left-to-right square-and-multiply: per bit, R=R*R mod N (SQUARE); if E[i]=1 then R=R*M mod N (MULT); NEXT decrements i; after i=0 go to DONE.
REQ-014 Modular products SHALL use bit-serial interleaved (Blakley) multiplication, one multiplier bit per cycle, MSB first: P=2P+a_k*B, then subtract N at most twice, keeping 0<=P<N; intermediates are WIDTH+2 bits wide.
REQ-015 Each modular multiplication SHALL complete exactly WIDTH+1 cycles after its start; total latency SHALL be at most WIDTH*(2*(WIDTH+1)+3)+4 cycles.
REQ-016 In DONE, cypher SHALL hold the result and done SHALL be 1 while go stays 1.
REQ-017 When go=0 in DONE, the block SHALL return to IDLE and drop done the next cycle; cypher SHALL hold until the next job's DONE.
REQ-018 For E=0, cypher SHALL be 1; for E=1, cypher SHALL be M.
REQ-019 If a precondition is violated, the cypher value is unspecified, but done SHALL still assert within the REQ-015 bound.
REQ-020 go=0 in any busy state SHALL NOT abort the job.

Reset
REQ-021 reset=0 SHALL asynchronously force IDLE, done=0, cypher=0, and clear all internal registers, including mid-operation.
REQ-022 After reset deasserts, a new job SHALL start only from IDLE with go=1.

Configuration
REQ-023 With macro RSA4K_SKIP_LEADING_ZEROS_EN defined, LOAD SHALL decrement i, one cycle per bit, past leading zero exponent bits before the first SQUARE; E=0 then goes directly to DONE with cypher=1.
REQ-024 Without RSA4K_SKIP_LEADING_ZEROS_EN, all WIDTH bits SHALL be processed. Results SHALL be identical in both builds; only latency differs.

Structure
REQ-025 Package rsa4k_pkg SHALL hold the WIDTH default constant and the FSM state enum typedef.
REQ-026 The modular multiplier SHALL be a sub-module rsa4k_modmul with ports clk, reset, start, a, b, n, p and done.

Verification
REQ-027 M=8, E=13, N=77: done asserts, then cypher=50.
REQ-028 After go=0 and a reset pulse, M=50, E=37, N=77: cypher=8 (round-trip decryption).
REQ-029 M=8, E=0, N=77: cypher=1; M=8, E=1, N=77: cypher=8.
REQ-030 4096-bit check: N=2^4096-1 (odd), M=2, E=4096: cypher=1 (2^4096 ≡ 1 mod N).
REQ-031 Reset mid-job while in SQUARE: done=0 and cypher=0 immediately; a following job with M=8, E=13, N=77 gives 50.
REQ-032 go held low after reset: done stays 0 and cypher stays 0 for 10000 cycles.
